ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 124 ++++++++++++
 tb/tb_ifetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: drives the instruction memory, holds the fetch PC and
// presents the instruction register, its PC and fetch/bubble statistics to decode.
module ifetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter logic [31:0] NOP_WORD     = 32'hE0000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_addr,
  output logic        i_req,
  input  logic        i_ready,
  input  logic [31:0] i_data,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] ir,
  output logic [3:0]  opcode,
  output logic [3:0]  opfunc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [15:0] fetch_count,
  output logic [15:0] bubble_count
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]  state_r, state_s;
  logic [31:0] fetch_pc_r, fetch_pc_s;
  logic [31:0] ir_r, ir_s;
  logic [31:0] pc_r, pc_s;
  logic [15:0] fetch_count_r, fetch_count_s;
  logic [15:0] bubble_count_r, bubble_count_s;
  logic        i_req_r;
  logic [1:0]  target_unused_s;

  // Word alignment discards the low target bits.
  assign target_unused_s = branch_target[1:0];

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

  // Next-state selection: branch redirect beats hazard stall beats memory handshake.
  always_comb begin
    state_s        = state_r;
    fetch_pc_s     = fetch_pc_r;
    ir_s           = ir_r;
    pc_s           = pc_r;
    fetch_count_s  = fetch_count_r;
    bubble_count_s = bubble_count_r;
    if (branch_taken) begin
      fetch_pc_s     = {branch_target[31:2], 2'b00};
      ir_s           = NOP_WORD;
      bubble_count_s = sat_inc(bubble_count_r);
      state_s        = RUN;
    end else begin
      case (state_r)
        BOOT: begin
          ir_s    = NOP_WORD;
          state_s = RUN;
        end
        RUN, WAIT: begin
          if (hazard) begin
            state_s = state_r;
          end else if (i_ready) begin
            ir_s          = i_data;
            pc_s          = fetch_pc_r;
            fetch_pc_s    = fetch_pc_r + 32'd4;
            fetch_count_s = sat_inc(fetch_count_r);
            state_s       = RUN;
          end else begin
            ir_s           = NOP_WORD;
            bubble_count_s = sat_inc(bubble_count_r);
            state_s        = WAIT;
          end
        end
        default: begin
          ir_s    = NOP_WORD;
          state_s = BOOT;
        end
      endcase
    end
  end

  // State registers; i_req is registered from the next state so it tracks RUN/WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= BOOT;
      fetch_pc_r     <= RESET_VECTOR;
      ir_r           <= NOP_WORD;
      pc_r           <= RESET_VECTOR;
      fetch_count_r  <= 16'd0;
      bubble_count_r <= 16'd0;
      i_req_r        <= 1'b0;
    end else begin
      state_r        <= state_s;
      fetch_pc_r     <= fetch_pc_s;
      ir_r           <= ir_s;
      pc_r           <= pc_s;
      fetch_count_r  <= fetch_count_s;
      bubble_count_r <= bubble_count_s;
      i_req_r        <= (state_s != BOOT);
    end
  end

  assign i_addr       = fetch_pc_r;
  assign i_req        = i_req_r;
  assign ir           = ir_r;
  assign pc           = pc_r;
  assign fetch_count  = fetch_count_r;
  assign bubble_count = bubble_count_r;
  assign opcode       = ir_r[31:28];
  assign opfunc       = ir_r[27:24];
  assign pc_plus4     = pc_r + 32'd4;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: accepted words are tracked in a scoreboard queue of
// {address, data} pushed when driven and popped after the capturing edge.
module tb_ifetch;

  localparam logic [31:0] NOP = 32'hE0000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_addr;
  logic        i_req;
  logic        i_ready = 1'b1;
  logic [31:0] i_data;
  logic        hazard = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  opfunc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [15:0] fetch_count;
  logic [15:0] bubble_count;

  logic [31:0] data_xor = 32'h0;
  logic [31:0] exp_fpc = 32'h0;
  logic [15:0] exp_fc = 16'd0;
  logic [15:0] exp_bc = 16'd0;
  logic [31:0] hold_ir, hold_pc;
  logic [63:0] sb_q[$];
  int total = 0;
  int passed = 0;
  int failed = 0;

  // Memory model returns the address (optionally tagged) as the instruction word.
  assign i_data = i_addr ^ data_xor;

  always #5 clk = ~clk;

  ifetch dut (
    .clk(clk), .reset(reset), .i_addr(i_addr), .i_req(i_req), .i_ready(i_ready),
    .i_data(i_data), .hazard(hazard), .branch_taken(branch_taken),
    .branch_target(branch_target), .ir(ir), .opcode(opcode), .opfunc(opfunc),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_count(fetch_count), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_accept();
    sb_q.push_back({exp_fpc, exp_fpc ^ data_xor});
    exp_fpc = exp_fpc + 32'd4;
    exp_fc  = exp_fc + 16'd1;
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_ir"}, ir, e[31:0]);
      chk({tag, "_pc"}, pc, e[63:32]);
      chk({tag, "_fc"}, {16'd0, fetch_count}, {16'd0, exp_fc});
      chk({tag, "_addr"}, i_addr, exp_fpc);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ir"}, ir, NOP);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_addr"}, i_addr, 32'h0);
    chk({tag, "_req"}, {31'd0, i_req}, 32'd0);
    chk({tag, "_fc"}, {16'd0, fetch_count}, 32'd0);
    chk({tag, "_bc"}, {16'd0, bubble_count}, 32'd0);
  endtask

  initial begin
    // Reset held several cycles
    step();
    chk_reset_state("rst1");
    step();
    step();
    chk_reset_state("rst3");

    // BOOT: one cycle, i_req low, no bubble counted
    reset = 1'b0;
    chk("boot_req", {31'd0, i_req}, 32'd0);
    step();
    chk("boot_ir", ir, NOP);
    chk("boot_bc", {16'd0, bubble_count}, 32'd0);
    chk("run_req", {31'd0, i_req}, 32'd1);
    chk("nop_opcode", {28'd0, opcode}, 32'hE);

    // Addr-as-data: ir = 0, 4, then tagged 8
    push_accept(); step(); pop_check("seq0");
    push_accept(); step(); pop_check("seq4");
    data_xor = 32'h10000000;
    push_accept(); step(); pop_check("seq8");
    chk("seq8_ir_lit", ir, 32'h10000008);
    chk("seq_fc3", {16'd0, fetch_count}, 32'd3);

    // Hazard freezes everything for two cycles
    hazard = 1'b1;
    hold_ir = ir;
    hold_pc = pc;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hz_ir", ir, hold_ir);
      chk("hz_pc", pc, hold_pc);
      chk("hz_addr", i_addr, 32'h0000000C);
      chk("hz_fc", {16'd0, fetch_count}, 32'd3);
      chk("hz_bc", {16'd0, bubble_count}, 32'd0);
    end
    hazard = 1'b0;
    push_accept(); step(); pop_check("hz_resume");

    // Branch wins over hazard; target is word-aligned
    data_xor = 32'h0;
    branch_taken = 1'b1;
    branch_target = 32'h00001003;
    hazard = 1'b1;
    step();
    exp_fpc = 32'h00001000;
    exp_bc = exp_bc + 16'd1;
    chk("br_addr", i_addr, 32'h00001000);
    chk("br_ir", ir, NOP);
    chk("br_bc", {16'd0, bubble_count}, {16'd0, exp_bc});
    branch_taken = 1'b0;
    hazard = 1'b0;
    push_accept(); step(); pop_check("br_first");

    // i_ready low three cycles: WAIT with stable address and bubbles
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_bc = exp_bc + 16'd1;
      chk("wt_addr", i_addr, 32'h00001004);
      chk("wt_req", {31'd0, i_req}, 32'd1);
      chk("wt_ir", ir, NOP);
      chk("wt_bc", {16'd0, bubble_count}, {16'd0, exp_bc});
    end
    i_ready = 1'b1;
    push_accept(); step(); pop_check("wt_accept");

    // Fetch PC wrap at the top of the address space
    branch_taken = 1'b1;
    branch_target = 32'hFFFFFFFC;
    step();
    exp_fpc = 32'hFFFFFFFC;
    exp_bc = exp_bc + 16'd1;
    branch_taken = 1'b0;
    push_accept(); step(); pop_check("wrap");
    chk("wrap_pc_plus4", pc_plus4, 32'h00000000);
    chk("wrap_opcode", {28'd0, opcode}, 32'hF);
    data_xor = 32'h3A000000;
    push_accept(); step(); pop_check("post_wrap");
    chk("pw_opcode", {28'd0, opcode}, 32'h3);
    chk("pw_opfunc", {28'd0, opfunc}, 32'hA);
    chk("pw_pc_plus4", pc_plus4, 32'h00000004);

    // Long stall drives bubble_count into saturation
    i_ready = 1'b0;
    for (int i = 0; i < (65535 - int'(exp_bc)); i++) begin
      step();
    end
    chk("sat_reach", {16'd0, bubble_count}, 32'h0000FFFF);
    for (int i = 0; i < 5; i++) begin
      step();
    end
    chk("sat_hold", {16'd0, bubble_count}, 32'h0000FFFF);
    chk("sat_fc", {16'd0, fetch_count}, {16'd0, exp_fc});

    // Reset mid-WAIT together with a branch request
    reset = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h00002000;
    step();
    chk_reset_state("rst_wait");
    reset = 1'b0;
    branch_taken = 1'b0;
    i_ready = 1'b1;
    data_xor = 32'h0;
    exp_fpc = 32'h0;
    exp_fc = 16'd0;
    sb_q.delete();
    step();
    chk("reboot_req", {31'd0, i_req}, 32'd1);
    chk("reboot_bc", {16'd0, bubble_count}, 32'd0);
    push_accept(); step(); pop_check("reboot0");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
